// File: rtl/mips_mem_pkg.sv
// Shared state encoding and address helpers for the MEM-stage data cache.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } dc_state_e;

  localparam int OFFSET_BITS = 2;
  localparam int BYTE_BITS   = 2;

  typedef struct packed {
    logic [OFFSET_BITS-1:0] offset;
    logic [BYTE_BITS-1:0]   bsel;
  } addr_low_t;

  function automatic addr_low_t addr_low(input logic [OFFSET_BITS+BYTE_BITS-1:0] lo);
    return addr_low_t'(lo);
  endfunction

  // Word accesses ignore the byte bits and enable every lane.
  function automatic logic [3:0] byte_en(input logic is_byte, input logic [BYTE_BITS-1:0] bsel);
    return is_byte ? (4'b0001 << bsel) : 4'b1111;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: per-line valid/tag plus word data with byte-enable writes.
module dcache_array
  import mips_mem_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4,
  parameter int TAG_BITS   = 22
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [INDEX_BITS-1:0]  index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic [31:0]            rd_word,
  input  logic                   wr_en,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [3:0]             wr_be,
  input  logic [31:0]            wr_data,
  input  logic                   tag_wr_en,
  input  logic [TAG_BITS-1:0]    tag_wr_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = LINES * LINE_WORDS;

  logic [LINES-1:0]                valid_q, valid_d;
  logic [TAG_BITS-1:0]             tag_mem  [LINES];
  logic [31:0]                     data_mem [WORDS];
  logic [INDEX_BITS+OFFSET_BITS-1:0] rd_slot, wr_slot;

  assign rd_slot  = {index, rd_offset};
  assign wr_slot  = {index, wr_offset};
  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_word  = data_mem[rd_slot];

  always_comb begin
    valid_d = valid_q;
    if (tag_wr_en) valid_d[index] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag and data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (tag_wr_en) tag_mem[index] <= tag_wr_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_mem[wr_slot][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM stage: direct-mapped write-through, no-write-allocate data cache with line refill.
//   state | meaning
//   IDLE  | serve load hits combinationally; launch fills and stores
//   FILL  | fetch four beats of the missing line from memory
//   WRITE | write the store through to memory, merge into cache on hit
module mem_stage_dcache
  import mips_mem_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cache_en,
  input  logic        mem_write,
  input  logic        is_LB_SB,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt_data,
  output logic [31:0] cache_data_out,
  output logic [1:0]  mem_block,
  output logic        freeze,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - BYTE_BITS;

  dc_state_e              state_q, state_d;
  logic [OFFSET_BITS-1:0] beat_q, beat_d;

  addr_low_t              lo;
  logic [TAG_BITS-1:0]    addr_tag;
  logic [INDEX_BITS-1:0]  addr_index;

  logic                   rd_valid, hit;
  logic [TAG_BITS-1:0]    rd_tag;
  logic [31:0]            rd_word;
  logic                   arr_wr_en, arr_tag_wr;
  logic [OFFSET_BITS-1:0] arr_wr_offset;
  logic [3:0]             arr_wr_be;
  logic [31:0]            arr_wr_data;

  assign lo         = addr_low(alu_result[OFFSET_BITS+BYTE_BITS-1:0]);
  assign addr_tag   = alu_result[31 -: TAG_BITS];
  assign addr_index = alu_result[OFFSET_BITS+BYTE_BITS +: INDEX_BITS];
  assign mem_block  = lo.bsel;
  assign hit        = rd_valid && (rd_tag == addr_tag);

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk         (clk),
    .rst_b       (rst_b),
    .index       (addr_index),
    .rd_offset   (lo.offset),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_word     (rd_word),
    .wr_en       (arr_wr_en),
    .wr_offset   (arr_wr_offset),
    .wr_be       (arr_wr_be),
    .wr_data     (arr_wr_data),
    .tag_wr_en   (arr_tag_wr),
    .tag_wr_data (addr_tag)
  );

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    freeze         = 1'b0;
    cache_data_out = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_be         = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    arr_wr_en      = 1'b0;
    arr_tag_wr     = 1'b0;
    arr_wr_offset  = beat_q;
    arr_wr_be      = 4'b1111;
    arr_wr_data    = mem_rdata;
    unique case (state_q)
      IDLE: begin
        if (cache_en) begin
          if (mem_write) begin
            freeze  = 1'b1;
            state_d = WRITE;
          end else if (hit) begin
            cache_data_out = rd_word;
          end else begin
            freeze  = 1'b1;
            beat_d  = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        freeze   = 1'b1;
        mem_req  = 1'b1;
        mem_be   = 4'b1111;
        mem_addr = {addr_tag, addr_index, beat_q, 2'b00};
        if (mem_ready) begin
          arr_wr_en = 1'b1;
          beat_d    = beat_q + 2'd1;
          // Tag and valid land only with the last beat so a partial line is never usable.
          if (beat_q == 2'd3) begin
            arr_tag_wr = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      WRITE: begin
        freeze    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {alu_result[31:2], 2'b00};
        mem_be    = byte_en(is_LB_SB, lo.bsel);
        mem_wdata = is_LB_SB ? {4{rt_data[7:0]}} : rt_data;
        if (mem_ready) begin
          arr_wr_en     = hit;
          arr_wr_offset = lo.offset;
          arr_wr_be     = mem_be;
          arr_wr_data   = mem_wdata;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Self-checking bench: randomized loads/stores against a main-memory and line-presence model.
module tb_mem_stage_dcache;

  logic        clk;
  logic        rst_b;
  logic        cache_en;
  logic        mem_write;
  logic        is_LB_SB;
  logic [31:0] alu_result;
  logic [31:0] rt_data;
  logic [31:0] cache_data_out;
  logic [1:0]  mem_block;
  logic        freeze;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  mem_stage_dcache #(.INDEX_BITS(6), .LINE_WORDS(4)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .cache_en       (cache_en),
    .mem_write      (mem_write),
    .is_LB_SB       (is_LB_SB),
    .alu_result     (alu_result),
    .rt_data        (rt_data),
    .cache_data_out (cache_data_out),
    .mem_block      (mem_block),
    .freeze         (freeze),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_be         (mem_be),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Main memory contents (word address) and which line address each cache slot holds.
  logic [31:0] mm [logic [29:0]];
  bit          line_v [64];
  logic [27:0] line_a [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mm.exists(wa)) return mm[wa];
    return {2'b10, wa} ^ 32'h5a5a_0000;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return line_v[a[9:4]] && (line_a[a[9:4]] == a[31:4]);
  endfunction

  task automatic clear_lines();
    for (int i = 0; i < 64; i++) line_v[i] = 1'b0;
  endtask

  task automatic drive(input logic en, input logic we, input logic lb,
                       input logic [31:0] a, input logic [31:0] d);
    cache_en   = en;
    mem_write  = we;
    is_LB_SB   = lb;
    alu_result = a;
    rt_data    = d;
  endtask

  // abort_after >= 0 pulls reset once that many beats have been accepted.
  task automatic do_load(input logic [31:0] a, input logic lb, input int abort_after);
    logic [31:0] exp;
    logic [1:0]  bb;
    int          d;
    @(negedge clk);
    drive(1'b1, 1'b0, lb, a, $urandom);
    #1;
    exp = mem_rd(a[31:2]);
    chk("mem_block", 32'(mem_block), 32'(a[1:0]));
    if (model_hit(a)) begin
      chk("hit_freeze", 32'(freeze), 32'd0);
      chk("hit_data", cache_data_out, exp);
      chk("hit_req", 32'(mem_req), 32'd0);
    end else begin
      chk("miss_freeze", 32'(freeze), 32'd1);
      chk("miss_data", cache_data_out, 32'd0);
      for (int b = 0; b < 4; b++) begin
        bb = 2'(b);
        if (b == abort_after) begin
          @(negedge clk);
          mem_ready = 1'b0;
          rst_b     = 1'b0;
          #1;
          chk("abort_req", 32'(mem_req), 32'd0);
          clear_lines();
          cache_en = 1'b0;
          @(negedge clk);
          rst_b = 1'b1;
          return;
        end
        d = $urandom_range(0, 2);
        for (int k = 0; k <= d; k++) begin
          @(negedge clk);
          mem_ready = (k == d);
          mem_rdata = (k == d) ? mem_rd({a[31:4], bb}) : $urandom;
          #1;
          chk("fill_req", 32'(mem_req), 32'd1);
          chk("fill_we", 32'(mem_we), 32'd0);
          chk("fill_be", 32'(mem_be), 32'hF);
          chk("fill_addr", mem_addr, {a[31:4], bb, 2'b00});
          chk("fill_freeze", 32'(freeze), 32'd1);
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      line_v[a[9:4]] = 1'b1;
      line_a[a[9:4]] = a[31:4];
      chk("post_freeze", 32'(freeze), 32'd0);
      chk("post_data", cache_data_out, exp);
      chk("post_req", 32'(mem_req), 32'd0);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic lb, input logic [31:0] data);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] w;
    int          d;
    @(negedge clk);
    drive(1'b1, 1'b1, lb, a, data);
    #1;
    ebe = lb ? (4'b0001 << a[1:0]) : 4'b1111;
    ewd = lb ? {4{data[7:0]}} : data;
    chk("st_issue_freeze", 32'(freeze), 32'd1);
    d = $urandom_range(0, 3);
    for (int k = 0; k <= d; k++) begin
      @(negedge clk);
      mem_ready = (k == d);
      #1;
      chk("st_req", 32'(mem_req), 32'd1);
      chk("st_we", 32'(mem_we), 32'd1);
      chk("st_be", 32'(mem_be), 32'(ebe));
      chk("st_addr", mem_addr, {a[31:2], 2'b00});
      chk("st_wdata", mem_wdata, ewd);
      chk("st_freeze", 32'(freeze), 32'd1);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    cache_en  = 1'b0;
    #1;
    chk("st_done_freeze", 32'(freeze), 32'd0);
    chk("st_done_req", 32'(mem_req), 32'd0);
    w = mem_rd(a[31:2]);
    for (int i = 0; i < 4; i++) if (ebe[i]) w[8*i +: 8] = ewd[8*i +: 8];
    mm[a[31:2]] = w;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [21:0] tags [4];
  logic [31:0] ra;

  initial begin
    rst_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    mem_rdata = '0;
    mem_ready = 1'b0;
    clear_lines();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_data", cache_data_out, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    mm[30'h10] = 32'h0000_00A0;
    mm[30'h11] = 32'h0000_00A1;
    mm[30'h12] = 32'h0000_00A2;
    mm[30'h13] = 32'h0000_00A3;

    do_load(32'h0000_0040, 1'b0, -1);
    chk("t1_word", cache_data_out, 32'h0000_00A0);
    do_load(32'h0000_0048, 1'b0, -1);
    chk("t2_word", cache_data_out, 32'h0000_00A2);
    do_store(32'h0000_004A, 1'b1, 32'h1234_5677);
    do_load(32'h0000_0048, 1'b0, -1);
    chk("t3_merge", cache_data_out, 32'h0077_00A2);

    do_store(32'h0000_8000, 1'b0, 32'hCAFE_F00D);
    do_load(32'h0000_8000, 1'b0, -1);
    chk("t4_word", cache_data_out, 32'hCAFE_F00D);

    @(negedge clk);
    cache_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      #1;
      chk("idle_rdy_freeze", 32'(freeze), 32'd0);
      chk("idle_rdy_req", 32'(mem_req), 32'd0);
    end
    mem_ready = 1'b0;
    do_load(32'h0000_0048, 1'b0, -1);
    chk("t6_still_hit", cache_data_out, 32'h0077_00A2);

    do_load(32'h0000_0450, 1'b0, 3);
    do_load(32'h0000_0450, 1'b0, -1);
    do_load(32'h0000_0048, 1'b0, -1);

    for (int i = 0; i < 4; i++) tags[i] = 22'($urandom);
    for (int n = 0; n < 200; n++) begin
      ra = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 9) < 7) do_load(ra, 1'($urandom_range(0, 1)), -1);
      else                          do_store(ra, 1'($urandom_range(0, 1)), $urandom);
    end

    @(negedge clk);
    cache_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
